// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl bus bundle: control-unit request side plus
// external memory side, grouped for the sequencer and its driver.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              Mem_Req;
  logic              Mem_WE;
  logic [ADDR_W-1:0] MAR_Addr;
  logic [DATA_W-1:0] MDR_Data_In;
  logic [DATA_W-1:0] MDR_Data_Load;
  logic              MDR_Load_En;
  logic              Mem_Busy;
  logic              Mem_Done;
  logic              Mem_Err;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] Mem_Wdata;
  logic [DATA_W-1:0] Mem_Rdata;
  logic              Mem_CS;
  logic              Mem_RW;
  logic              Mem_Ready;

  modport slave (
    input  Mem_Req, Mem_WE, MAR_Addr, MDR_Data_In,
    input  Mem_Rdata, Mem_Ready,
    output MDR_Data_Load, MDR_Load_En, Mem_Busy,
    output Mem_Done, Mem_Err, Mem_Addr, Mem_Wdata,
    output Mem_CS, Mem_RW
  );

  modport master (
    output Mem_Req, Mem_WE, MAR_Addr, MDR_Data_In,
    output Mem_Rdata, Mem_Ready,
    input  MDR_Data_Load, MDR_Load_En, Mem_Busy,
    input  Mem_Done, Mem_Err, Mem_Addr, Mem_Wdata,
    input  Mem_CS, Mem_RW
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-word MAR/MDR memory access sequencer.
// Define MEM_TIMEOUT_EN to add the not-ready timeout and ERR state.
module mem_access_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input logic              clk,
  input logic              rst,
  mem_access_ctrl_if.slave bus
);

`ifdef MEM_TIMEOUT_EN
  typedef enum logic [1:0] {
    IDLE, ACCESS, DONE, ERR
  } state_t;

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             tmo;
`else
  typedef enum logic [1:0] {
    IDLE, ACCESS, DONE
  } state_t;

  logic unused_tmo;
  assign unused_tmo = (TIMEOUT > 0);
`endif

  state_t            state_q;
  state_t            state_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ready;
  logic              in_idle;
  logic              in_acc;

  assign ready   = bus.Mem_Ready;
  assign in_idle = (state_q == IDLE);
  assign in_acc  = (state_q == ACCESS);

`ifdef MEM_TIMEOUT_EN
  assign tmo = !ready &&
               (cnt_q == CNT_W'(TIMEOUT - 1));
`endif

  // next-state decode; ready beats the terminal count
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.Mem_Req) state_d = ACCESS;
      end
      ACCESS: begin
        if (ready) state_d = DONE;
`ifdef MEM_TIMEOUT_EN
        else if (tmo) state_d = ERR;
`endif
      end
      DONE:    state_d = IDLE;
`ifdef MEM_TIMEOUT_EN
      ERR:     state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // state register; reset drops any access in flight
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // capture the request so the memory side stays stable
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (in_idle && bus.Mem_Req) begin
      we_q    <= bus.Mem_WE;
      addr_q  <= bus.MAR_Addr;
      wdata_q <= bus.MDR_Data_In;
    end
  end

  // read data held until the next successful read
  always_ff @(posedge clk) begin
    if (rst)
      rdata_q <= '0;
    else if (in_acc && ready && !we_q)
      rdata_q <= bus.Mem_Rdata;
  end

`ifdef MEM_TIMEOUT_EN
  // not-ready cycle count, cleared while idle
  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else if (in_idle)
      cnt_q <= '0;
    else if (in_acc && !ready)
      cnt_q <= cnt_q + 1'b1;
  end

  assign bus.Mem_Err = (state_q == ERR);
  assign bus.Mem_Done = (state_q == DONE) ||
                        (state_q == ERR);
`else
  assign bus.Mem_Err  = 1'b0;
  assign bus.Mem_Done = (state_q == DONE);
`endif

  assign bus.Mem_CS        = in_acc;
  assign bus.Mem_Busy      = !in_idle;
  assign bus.MDR_Load_En   = (state_q == DONE) && !we_q;
  assign bus.MDR_Data_Load = rdata_q;
  assign bus.Mem_Addr      = addr_q;
  assign bus.Mem_Wdata     = wdata_q;
  assign bus.Mem_RW        = we_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: random and directed accesses against a
// transaction-level memory model, checked by a scoreboard monitor.
module tb_mem_access_ctrl;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int TMO = 4;
`ifdef MEM_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  typedef struct {
    bit          err;
    bit          load;
    logic [15:0] mdr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_access_ctrl #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t        sb[$];
  exp_t        got;
  logic [15:0] mem[logic [15:0]];
  logic [15:0] last_mdr  = '0;
  bit          exp_done  = 1'b0;
  bit          cur_we    = 1'b0;
  logic [15:0] cur_addr  = '0;
  logic [15:0] cur_wdata = '0;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // scoreboard monitor: bus stability, pulse timing, completions
  always @(negedge clk) begin
    chk("done_timing", 32'(bus.Mem_Done), 32'(exp_done));
    if (bus.Mem_CS) begin
      chk("addr_stable", 32'(bus.Mem_Addr), 32'(cur_addr));
      chk("rw_stable", 32'(bus.Mem_RW), 32'(cur_we));
      if (cur_we)
        chk("wdata_stable", 32'(bus.Mem_Wdata),
            32'(cur_wdata));
    end
    if (!bus.Mem_Done) begin
      chk("err_quiet", 32'(bus.Mem_Err), 32'd0);
      chk("load_quiet", 32'(bus.MDR_Load_En), 32'd0);
    end else if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_unexpected_done: got done want none");
    end else begin
      got = sb.pop_front();
      chk("done_err", 32'(bus.Mem_Err), 32'(got.err));
      chk("done_load", 32'(bus.MDR_Load_En), 32'(got.load));
      chk("done_mdr", 32'(bus.MDR_Data_Load), 32'(got.mdr));
    end
  end

  // one access; starts and ends #1 after an edge in an IDLE cycle
  task automatic txn(bit we, logic [15:0] a,
                     logic [15:0] d, int waits, bit hold);
    exp_t        e;
    logic [15:0] rd;
    int          k;
    bit          fin;
    rd     = mem.exists(a) ? mem[a] : 16'($urandom);
    e.err  = TMO_EN && (waits >= TMO);
    e.load = !we && !e.err;
    if (e.load) last_mdr = rd;
    e.mdr  = last_mdr;
    if (we && !e.err) mem[a] = d;
    sb.push_back(e);
    cur_we = we; cur_addr = a; cur_wdata = d;
    bus.Mem_Req     = 1'b1;
    bus.Mem_WE      = we;
    bus.MAR_Addr    = a;
    bus.MDR_Data_In = d;
    bus.Mem_Ready   = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(bus.Mem_Busy), 32'd0);
    chk("idle_cs", 32'(bus.Mem_CS), 32'd0);
    @(posedge clk); #1;
    if (!hold) bus.Mem_Req = 1'b0;
    bus.MAR_Addr    = 16'($urandom);
    bus.MDR_Data_In = 16'($urandom);
    bus.Mem_WE      = 1'($urandom);
    if (hold) begin
      bus.MAR_Addr = a; bus.MDR_Data_In = d; bus.Mem_WE = we;
    end
    k = 1; fin = 1'b0;
    while (!fin) begin
      bus.Mem_Ready = (k > waits);
      bus.Mem_Rdata = bus.Mem_Ready ? rd : 16'($urandom);
      @(negedge clk);
      chk("acc_cs", 32'(bus.Mem_CS), 32'd1);
      chk("acc_busy", 32'(bus.Mem_Busy), 32'd1);
      @(posedge clk); #1;
      if (bus.Mem_Ready) fin = 1'b1;
      else if (TMO_EN && k == TMO) fin = 1'b1;
      k++;
      if (k > 64) begin
        total++; bad++; fin = 1'b1;
        $display("FAIL access_bound: got no end want end");
      end
    end
    bus.Mem_Ready = 1'b0;
    exp_done = 1'b1;
    @(negedge clk);
    chk("done_cs", 32'(bus.Mem_CS), 32'd0);
    chk("done_busy", 32'(bus.Mem_Busy), 32'd1);
    @(posedge clk); #1;
    exp_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Mem_Req = 0; bus.Mem_WE = 0; bus.MAR_Addr = '0;
    bus.MDR_Data_In = '0; bus.Mem_Rdata = '0;
    bus.Mem_Ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cs", 32'(bus.Mem_CS), 32'd0);
    chk("rst_busy", 32'(bus.Mem_Busy), 32'd0);
    chk("rst_mdr", 32'(bus.MDR_Data_Load), 32'd0);
    chk("rst_addr", 32'(bus.Mem_Addr), 32'd0);
    chk("rst_wdata", 32'(bus.Mem_Wdata), 32'd0);
    chk("rst_rw", 32'(bus.Mem_RW), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    mem[16'h1234] = 16'hBEEF;
    txn(1'b0, 16'h1234, 16'h0, 0, 1'b0);
    txn(1'b1, 16'h00FF, 16'hA5A5, 3, 1'b0);
    if (TMO_EN) begin
      txn(1'b0, 16'h0007, 16'h0, 20, 1'b0);
      txn(1'b0, 16'h00FF, 16'h0, 3, 1'b0);
    end
    txn(1'b0, 16'h00FF, 16'h0, 1, 1'b1);
    txn(1'b1, 16'h0003, 16'h5A5A, 0, 1'b1);
    txn(1'b0, 16'h0003, 16'h0, 0, 1'b1);
    bus.Mem_Req = 1'b0;

    cur_we = 1'b0; cur_addr = 16'h0042;
    bus.Mem_Req = 1'b1; bus.Mem_WE = 1'b0;
    bus.MAR_Addr = 16'h0042; bus.Mem_Ready = 1'b0;
    @(posedge clk); #1;
    bus.Mem_Req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("arst_cs", 32'(bus.Mem_CS), 32'd0);
    chk("arst_busy", 32'(bus.Mem_Busy), 32'd0);
    chk("arst_mdr", 32'(bus.MDR_Data_Load), 32'd0);
    chk("arst_addr", 32'(bus.Mem_Addr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_mdr = '0;

    for (int i = 0; i < 60; i++) begin
      logic [15:0] ra;
      bit          rh;
      ra = {12'h0, 4'($urandom)};
      rh = 1'($urandom);
      txn(1'($urandom), ra, 16'($urandom),
          $urandom_range(0, 5), rh);
      bus.Mem_Req = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    @(negedge clk);
    chk("end_busy", 32'(bus.Mem_Busy), 32'd0);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
